universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//   Parametrised successor to the 4-bit PIPO register. Holds a WIDTH-bit word with
//   parallel load, logical shift and rotate in both directions, plus two self-timed
//   framing modes: serialise a loaded word (TX) and deserialise a serial stream (RX).
//   Sits between parallel datapaths and single-wire serial links.
// PARAMETERS
//   WIDTH    4   Word width in bits. Must be at least 2.
//   RST_VAL  0   Value loaded into OUT by reset (WIDTH bits).
// PORTS
//   CLK     in   1      Clock. All state updates on the rising edge.
//   RST     in   1      Reset. Synchronous, active-high.
//   EN      in   1      Operation strobe. MODE is acted on only when EN=1 and BUSY=0.
//   MODE    in   3      Operation select (see BEHAVIOUR).
//   IN      in   WIDTH  Parallel data in.
//   SIN_L   in   1      Serial in at the MSB end (used by SHR).
//   SIN_R   in   1      Serial in at the LSB end (used by SHL and RX).
//   OUT     out  WIDTH  Register contents (parallel out).
//   SOUT_L  out  1      Serial out = OUT[WIDTH-1].
//   SOUT_R  out  1      Serial out = OUT[0].
//   BUSY    out  1      High while a TX or RX frame is in progress.
//   DONE    out  1      One-cycle pulse when a frame completes.
// BEHAVIOUR
//   Reset: when RST=1 at a rising edge:
//     OUT=RST_VAL, BUSY=0, DONE=0, state=IDLE, bit counter=0.
//     RST takes priority over every other input, including mid-frame.
//   MODE, acted on in IDLE with EN=1; single-cycle modes take effect at the same edge:
//     000 HOLD    OUT unchanged.
//     001 LOAD    OUT<=IN.
//     010 SHL     OUT<={OUT[W-2:0],SIN_R}.
//     011 SHR     OUT<={SIN_L,OUT[W-1:1]}.
//     100 ROL     OUT<={OUT[W-2:0],OUT[W-1]}.
//     101 ROR     OUT<={OUT[0],OUT[W-1:1]}.
//     110 TX      OUT<=IN; state->TX; counter=0; BUSY=1.
//     111 RX      OUT unchanged; state->RX; counter=0; BUSY=1.
//   IDLE with EN=0: OUT holds.
//   FSM states: IDLE, TX, RX. Counter width is $clog2(WIDTH+1).
//   TX frame:
//     - Each edge in TX: OUT<={OUT[W-2:0],1'b0}; counter++.
//     - SOUT_L presents the loaded word MSB first, one bit per cycle, for the WIDTH
//       cycles after the load edge.
//     - On the edge where counter reaches WIDTH: state->IDLE, BUSY=0, DONE=1 for the
//       following cycle, OUT=0.
//   RX frame:
//     - Each edge in RX: OUT<={OUT[W-2:0],SIN_R}; counter++.
//     - The first sampled bit becomes the MSB.
//     - After WIDTH shifts: state->IDLE, BUSY=0, DONE=1 for one cycle, OUT=received word.
//   While BUSY=1, EN, MODE and IN are ignored.
//   DONE is registered and is 0 in every cycle other than the one after frame completion.
//     A new EN in that DONE cycle is accepted (back-to-back frames allowed).
//   SOUT_L and SOUT_R are combinational from OUT, so they are valid in the same cycle as OUT.
// CONFIGURATION
//   USR_PARITY_EN defined:
//     - Adds output PAR (1 bit) = registered even parity (^) of the value written into OUT.
//     - Updated on every edge that changes OUT; reset to ^RST_VAL.
//     - Also adds output PERR: high for the DONE cycle of an RX frame when SIN_R,
//       sampled on the edge immediately after the last data bit, != parity of the
//       received word. That edge is part of the frame, so BUSY stays high one extra cycle.
//   USR_PARITY_EN undefined: no PAR/PERR ports; RX frame is exactly WIDTH bits.
// TESTING  (WIDTH=4, RST_VAL=0)
//   1. Hold RST=1 for 2 edges, then RST=0, EN=0
//      -> OUT=0000, BUSY=0, DONE=0; OUT holds through 5 idle edges.
//   2. LOAD IN=1010; SHL with SIN_R=1 -> OUT=0101; ROR -> OUT=1010; SHR with SIN_L=0 -> OUT=0101.
//   3. TX with IN=1011 -> SOUT_L=1,0,1,1 on 4 consecutive cycles; BUSY=1 for 4 cycles;
//      DONE=1 for one cycle; OUT=0000. A LOAD issued mid-frame is ignored.
//   4. RX with SIN_R=1,1,0,1 -> OUT=1101 with DONE pulse; an immediate second RX
//      with SIN_R=0,0,1,0 -> OUT=0010.
//   5. RST=1 on the 2nd cycle of a TX of 1111 -> next cycle OUT=0000, BUSY=0, DONE never asserts.
//   6. With USR_PARITY_EN: RX 1101 followed by parity bit 0 -> PAR=1, PERR=1;
//      the same word with parity bit 1 -> PERR=0.

Source files
------------

// File: rtl/usr_if.sv
// Bundles the operation strobe, data and status of universal_shift_reg.
// USR_PARITY_EN adds the par/perr status lines.
interface usr_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] in;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] out;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;
`ifdef USR_PARITY_EN
    logic             par;
    logic             perr;

    modport master (output en, mode, in, sin_l, sin_r,
                    input  out, sout_l, sout_r, busy, done, par, perr);
    modport slave  (input  en, mode, in, sin_l, sin_r,
                    output out, sout_l, sout_r, busy, done, par, perr);
`else
    modport master (output en, mode, in, sin_l, sin_r,
                    input  out, sout_l, sout_r, busy, done);
    modport slave  (input  en, mode, in, sin_l, sin_r,
                    output out, sout_l, sout_r, busy, done);
`endif
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with parallel load, shift/rotate and self-timed
// TX/RX framing. Optional parity generation/check under macro USR_PARITY_EN.
module universal_shift_reg #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input logic   clk,
    input logic   rst,
    usr_if.slave  bus
);
    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_RX   = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] out_r, out_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             par_r;
    logic             perr_r, perr_s;

    function automatic logic even_par(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Next-state, next-word and frame bookkeeping.
    always_comb begin
        state_s = state_r;
        out_s   = out_r;
        cnt_s   = cnt_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        perr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.en) begin
                    case (bus.mode)
                        3'b000: out_s = out_r;
                        3'b001: out_s = bus.in;
                        3'b010: out_s = {out_r[WIDTH-2:0], bus.sin_r};
                        3'b011: out_s = {bus.sin_l, out_r[WIDTH-1:1]};
                        3'b100: out_s = {out_r[WIDTH-2:0], out_r[WIDTH-1]};
                        3'b101: out_s = {out_r[0], out_r[WIDTH-1:1]};
                        3'b110: begin
                            out_s   = bus.in;
                            state_s = ST_TX;
                            cnt_s   = {CNT_W{1'b0}};
                            busy_s  = 1'b1;
                        end
                        3'b111: begin
                            state_s = ST_RX;
                            cnt_s   = {CNT_W{1'b0}};
                            busy_s  = 1'b1;
                        end
                        default: out_s = out_r;
                    endcase
                end else begin
                    out_s = out_r;
                end
            end
            ST_TX: begin
                out_s = {out_r[WIDTH-2:0], 1'b0};
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    out_s   = {WIDTH{1'b0}};
                end else begin
                    state_s = ST_TX;
                end
            end
            ST_RX: begin
`ifdef USR_PARITY_EN
                // One extra edge after the data bits samples the parity bit.
                if (cnt_r == CNT_FULL) begin
                    out_s   = out_r;
                    perr_s  = bus.sin_r ^ even_par(out_r);
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    out_s = {out_r[WIDTH-2:0], bus.sin_r};
                    cnt_s = cnt_r + CNT_W'(1);
                end
`else
                out_s = {out_r[WIDTH-2:0], bus.sin_r};
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_RX;
                end
`endif
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            out_r   <= RST_VAL;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            par_r   <= even_par(RST_VAL);
            perr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            out_r   <= out_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            par_r   <= even_par(out_s);
            perr_r  <= perr_s;
        end
    end

    assign bus.out    = out_r;
    assign bus.sout_l = out_r[WIDTH-1];
    assign bus.sout_r = out_r[0];
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
`ifdef USR_PARITY_EN
    assign bus.par    = par_r;
    assign bus.perr   = perr_r;
`else
    logic unused_par_s;
    assign unused_par_s = par_r ^ perr_r ^ perr_s;
`endif
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed plus randomized bench for universal_shift_reg (WIDTH=4, RST_VAL=0) against
// an arithmetic reference model.
module tb_universal_shift_reg;
    localparam int W = 4;
`ifdef USR_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    usr_if #(.WIDTH(W)) bus ();

    universal_shift_reg #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: word as an integer 0..15 plus frame bookkeeping.
    int m_out = 0, m_busy = 0, m_done = 0, m_perr = 0, m_tx = 0, m_k = 0, m_word = 0;

    function automatic int par_of(input int v);
        return $countones(v) % 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input int md, input int din,
                              input int sl, input int sr);
        if (r) begin
            m_out = 0; m_busy = 0; m_done = 0; m_perr = 0; m_k = 0;
            return;
        end
        m_done = 0;
        m_perr = 0;
        if (m_busy != 0) begin
            if (m_tx != 0) begin
                m_k++;
                m_out = (m_word << m_k) % 16;
                if (m_k == W) begin m_busy = 0; m_done = 1; m_out = 0; end
            end else if (m_k < W) begin
                m_out = (m_out * 2 + sr) % 16;
                m_k++;
                if (m_k == W && !PAR_EN) begin m_busy = 0; m_done = 1; end
            end else begin
                m_perr = (sr != par_of(m_out)) ? 1 : 0;
                m_busy = 0;
                m_done = 1;
            end
        end else if (e) begin
            case (md)
                1: m_out = din;
                2: m_out = (m_out * 2 + sr) % 16;
                3: m_out = m_out / 2 + sl * 8;
                4: m_out = (m_out * 2) % 16 + m_out / 8;
                5: m_out = m_out / 2 + (m_out % 2) * 8;
                6: begin m_word = din; m_out = din; m_tx = 1; m_busy = 1; m_k = 0; end
                7: begin m_tx = 0; m_busy = 1; m_k = 0; end
                default: m_out = m_out;
            endcase
        end
    endtask

    task automatic check_all();
        check("out",    {28'd0, bus.out}, m_out);
        check("busy",   {31'd0, bus.busy}, m_busy);
        check("done",   {31'd0, bus.done}, m_done);
        check("sout_l", {31'd0, bus.sout_l}, m_out / 8);
        check("sout_r", {31'd0, bus.sout_r}, m_out % 2);
`ifdef USR_PARITY_EN
        check("par",    {31'd0, bus.par}, par_of(m_out));
        check("perr",   {31'd0, bus.perr}, m_perr);
`endif
    endtask

    task automatic cycle(input bit r, input bit e, input int md, input int din,
                         input int sl, input int sr);
        rst       = r;
        bus.en    = e;
        bus.mode  = 3'(md);
        bus.in    = 4'(din);
        bus.sin_l = 1'(sl);
        bus.sin_r = 1'(sr);
        @(posedge clk);
        model_edge(r, e, md, din, sl, sr);
        #1;
        check_all();
    endtask

    initial begin
        int tx_bits[4] = '{1, 0, 1, 1};
        int rx_a[4]    = '{1, 1, 0, 1};
        int rx_b[4]    = '{0, 0, 1, 0};
        bus.en = 1'b0; bus.mode = 3'd0; bus.in = 4'd0; bus.sin_l = 1'b0; bus.sin_r = 1'b0;

        // Reset and idle hold
        cycle(1'b1, 1'b0, 0, 0, 0, 0);
        cycle(1'b1, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1, 15, 1, 1);
            check("idle_hold", {28'd0, bus.out}, 32'h0);
        end

        // Load / shift / rotate
        cycle(1'b0, 1'b1, 1, 10, 0, 0);
        check("load", {28'd0, bus.out}, 32'hA);
        cycle(1'b0, 1'b1, 2, 0, 0, 1);
        check("shl", {28'd0, bus.out}, 32'h5);
        cycle(1'b0, 1'b1, 5, 0, 0, 0);
        check("ror", {28'd0, bus.out}, 32'hA);
        cycle(1'b0, 1'b1, 3, 0, 0, 0);
        check("shr", {28'd0, bus.out}, 32'h5);

        // TX 1011 with a LOAD attempted mid-frame
        cycle(1'b0, 1'b1, 6, 11, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("tx_sout", {31'd0, bus.sout_l}, tx_bits[i]);
            check("tx_busy", {31'd0, bus.busy}, 32'h1);
            cycle(1'b0, 1'b1, 1, 6, 0, 0);
        end
        check("tx_done", {31'd0, bus.done}, 32'h1);
        check("tx_out", {28'd0, bus.out}, 32'h0);
        cycle(1'b0, 1'b0, 0, 0, 0, 0);
        check("tx_done_clr", {31'd0, bus.done}, 32'h0);

        // RX 1101 then back-to-back RX 0010
        cycle(1'b0, 1'b1, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 0, 0, rx_a[i]);
        if (PAR_EN) cycle(1'b0, 1'b0, 0, 0, 0, 1);
        check("rx1_out", {28'd0, bus.out}, 32'hD);
        check("rx1_done", {31'd0, bus.done}, 32'h1);
        cycle(1'b0, 1'b1, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 0, 0, rx_b[i]);
        if (PAR_EN) cycle(1'b0, 1'b0, 0, 0, 0, 1);
        check("rx2_out", {28'd0, bus.out}, 32'h2);
        check("rx2_done", {31'd0, bus.done}, 32'h1);

        // Reset mid-TX
        cycle(1'b0, 1'b1, 6, 15, 0, 0);
        cycle(1'b0, 1'b0, 0, 0, 0, 0);
        cycle(1'b1, 1'b0, 0, 0, 0, 0);
        check("rst_tx_out", {28'd0, bus.out}, 32'h0);
        check("rst_tx_busy", {31'd0, bus.busy}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 0, 0, 0, 0);
            check("rst_tx_nodone", {31'd0, bus.done}, 32'h0);
        end

`ifdef USR_PARITY_EN
        // Parity error and clean parity on RX 1101
        cycle(1'b0, 1'b1, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 0, 0, rx_a[i]);
        cycle(1'b0, 1'b0, 0, 0, 0, 0);
        check("par_bad_par", {31'd0, bus.par}, 32'h1);
        check("par_bad_perr", {31'd0, bus.perr}, 32'h1);
        cycle(1'b0, 1'b1, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 0, 0, rx_a[i]);
        cycle(1'b0, 1'b0, 0, 0, 0, 1);
        check("par_ok_perr", {31'd0, bus.perr}, 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
